stream_mux_n: RTL and testbench
===============================

STREAM_MUX_N -- requirements
Module: stream_mux_n

Interface
REQ-001 Parameter N, default 4, number of input channels; N SHALL be at least 2.
REQ-002 Parameter W, default 8, data width in bits per channel; W SHALL be at least 1.
REQ-003 Parameter SW, default $clog2(N), width of the select and channel-ID fields.
REQ-004 clk  input  1  single clock for all state, rising edge.
REQ-005 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 mode  input  1  0 selects fixed mode (sel chooses the channel); 1 selects round-robin mode.
REQ-007 sel  input  SW  channel chosen in fixed mode; a value of N or above SHALL grant nothing.
REQ-008 in_valid  input  N  per-channel valid.
REQ-009 in_ready  output  N  per-channel ready.
REQ-010 in_data  input  N*W  channel k occupies bits [k*W +: W].
REQ-011 in_last  input  N  per-channel end-of-packet flag.
REQ-012 out_valid  output  1  output register holds a beat.
REQ-013 out_ready  input  1  downstream accepts the beat.
REQ-014 out_data  output  W  registered data.
REQ-015 out_last  output  1  registered last flag.
REQ-016 out_ch  output  SW  source channel of the registered beat.

Function
REQ-017 The stage SHALL be "free" when out_valid=0 or out_ready=1.
REQ-018 The block SHALL select at most one grant channel g per cycle; in_ready SHALL be one-hot or zero.
- in_ready[g] = free AND grant-eligible.
REQ-019 A transfer on channel g SHALL occur when in_valid[g] and in_ready[g] are both 1.
- On the next edge, out_data, out_last and out_ch load in_data[g], in_last[g] and g, and out_valid becomes 1.
- Latency: one cycle.
REQ-020 When free and no transfer occurs, out_valid SHALL go to 0 on the next edge.
- When not free, all output registers SHALL hold their values.
REQ-021 Full throughput: with out_ready held at 1, one beat per cycle SHALL be sustained.
REQ-022 Fixed mode: the grant SHALL be channel sel.
- in_ready[sel] SHALL follow free independently of in_valid.
- All other in_ready SHALL be 0.
REQ-023 Round-robin mode: priority pointer p SHALL scan p, p+1, ..., N-1, 0, ..., p-1.
- The first channel with in_valid=1 is granted.
- in_ready of a channel SHALL be asserted only together with its in_valid.
REQ-024 After a transfer from channel g, p SHALL become g+1, wrapping from N-1 to 0.
- Without a transfer, p SHALL hold.
- Fixed-mode transfers SHALL also update p.
REQ-025 Changes to mode or sel SHALL affect arbitration combinationally in the same cycle, subject to REQ-032.
- Beats already in the output register SHALL be unaffected.
REQ-026 If only one channel is valid in round-robin mode, it SHALL be granted every free cycle regardless of p.

Reset
REQ-027 While rst_n=0: out_valid=0, out_data=0, out_last=0, out_ch=0, p=0, lock state cleared.
REQ-028 in_ready SHALL be 0 during reset.
REQ-029 Reset asserted mid-packet or mid-stall SHALL discard the held beat; no partial state survives.
REQ-030 On the first edge after deassertion, the block SHALL behave as idle with p=0.

Configuration
REQ-031 Macro STREAM_MUX_PKT_LOCK_EN SHALL select packet-lock behaviour.
REQ-032 With the macro defined, a two-state FSM (UNLOCKED, LOCKED) SHALL operate.
- A transfer with in_last=0 in UNLOCKED enters LOCKED on the locked channel g.
- In LOCKED, only g is eligible regardless of mode, sel and p.
- A transfer with in_last=1 on g returns to UNLOCKED.
- A single-beat packet (last=1 in UNLOCKED) stays UNLOCKED.
REQ-033 Without the macro, arbitration SHALL be per beat.
- in_last is carried through to out_last only.
- The FSM logic SHALL be absent.

Structure
REQ-034 Package stream_mux_pkg SHALL hold:
- the mode encodings MODE_FIXED=0 and MODE_RR=1;
- the lock-state typedef (UNLOCKED, LOCKED);
- default constants for N and W.
REQ-035 Sub-module rr_arbiter SHALL implement the parametrised round-robin grant.
- Inputs: request vector, pointer p, advance strobe.
- Outputs: one-hot grant and the updated pointer.
REQ-036 stream_mux_n SHALL instantiate one rr_arbiter and contain the output register and the lock FSM.

Verification
REQ-037 Reset: rst_n=0 mid-stream -> out_valid=0 and in_ready=0 immediately; after release, first grant starts from channel 0.
REQ-038 Round robin with N=4: all in_valid=1111, out_ready=1 -> out_ch sequence 0,1,2,3,0 on consecutive cycles, one beat per cycle.
REQ-039 Fixed mode: mode=0, sel=2, in_data[2]=8'hA5 -> out_data=A5 and out_ch=2 one cycle later; in_ready[0,1,3]=0 throughout.
REQ-040 Backpressure: out_ready=0 for 3 cycles with out_valid=1 -> out_data stable and in_ready=0000; the beat transfers on the first out_ready=1 cycle.
REQ-041 Wrap and skip: p=3, in_valid=0101 -> grant channel 0, then channel 2.
REQ-042 With STREAM_MUX_PKT_LOCK_EN: channel 1 sends a 3-beat packet while channel 2 is valid -> out_ch=1,1,1, then 2; a sel change mid-packet is ignored.

Source files
------------

// File: rtl/stream_mux_pkg.sv
// Purpose: shared encodings and defaults for the N-to-1 stream multiplexer.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package stream_mux_pkg;

    // Arbitration mode encodings carried on the mode input.
    localparam logic MODE_FIXED = 1'b0;
    localparam logic MODE_RR    = 1'b1;

    // Default geometry: channel count and per-channel data width.
    localparam int DEFAULT_N = 4;
    localparam int DEFAULT_W = 8;

    // Packet-lock state, used only when STREAM_MUX_PKT_LOCK_EN is defined.
    typedef enum logic {
        UNLOCKED = 1'b0,
        LOCKED   = 1'b1
    } lock_state_t;

endpackage : stream_mux_pkg

// File: rtl/stream_mux_rr_arbiter.sv
// Purpose: combinational round-robin grant over a request vector, scanning from ptr upward with wrap.
// Latency: zero cycles (purely combinational); the pointer register lives in the parent.
// Backpressure: none; ptr_next advances only when the parent strobes advance.
//
// Ports:
//   req       - per-channel request vector
//   ptr       - current priority pointer (highest priority channel)
//   advance   - a transfer happened on the granted channel this cycle
//   grant     - one-hot grant (zero when nothing requests)
//   grant_idx - binary index of the granted channel (0 when no grant)
//   ptr_next  - granted channel + 1 (wrapping) when advancing, else ptr
module rr_arbiter #(
    parameter int N  = 4,
    parameter int SW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [SW-1:0] ptr,
    input  logic          advance,
    output logic [N-1:0]  grant,
    output logic [SW-1:0] grant_idx,
    output logic [SW-1:0] ptr_next
);

    logic found;
    int   scan_idx;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        scan_idx  = 0;
        // Walk ptr, ptr+1, ..., N-1, 0, ..., ptr-1 and take the first requester.
        for (int i = 0; i < N; i++) begin
            scan_idx = (int'(ptr) + i) % N;
            if (!found && req[scan_idx]) begin
                found           = 1'b1;
                grant[scan_idx] = 1'b1;
                grant_idx       = SW'(scan_idx);
            end
        end

        ptr_next = ptr;
        if (advance && found) begin
            ptr_next = (int'(grant_idx) == N - 1) ? '0 : SW'(int'(grant_idx) + 1);
        end
    end

endmodule : rr_arbiter

// File: rtl/stream_mux_n.sv
// Purpose: N-channel valid/ready stream mux, fixed (sel) or round-robin arbitration, registered output.
// Latency: one cycle from input handshake to out_valid/out_data/out_last/out_ch.
// Backpressure: in_ready only while the output register is empty or draining (out_ready=1); full rate.
//
// Optional feature: define STREAM_MUX_PKT_LOCK_EN to hold the grant on one channel from the
// first beat of a packet until its in_last beat (UNLOCKED/LOCKED FSM).
//
// Ports:
//   clk, rst_n           - clock, asynchronous active-low reset
//   mode, sel            - arbitration mode (MODE_FIXED/MODE_RR), fixed-mode channel select
//   in_valid/in_ready    - per-channel handshake; in_ready is one-hot or zero
//   in_data, in_last     - channel k data at [k*W +: W], per-channel end-of-packet
//   out_valid/out_ready  - output handshake
//   out_data/out_last/out_ch - registered beat and its source channel
module stream_mux_n
    import stream_mux_pkg::*;
#(
    parameter int N  = DEFAULT_N,
    parameter int W  = DEFAULT_W,
    parameter int SW = $clog2(N)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            mode,
    input  logic [SW-1:0]   sel,
    input  logic [N-1:0]    in_valid,
    output logic [N-1:0]    in_ready,
    input  logic [N*W-1:0]  in_data,
    input  logic [N-1:0]    in_last,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [W-1:0]    out_data,
    output logic            out_last,
    output logic [SW-1:0]   out_ch
);

    logic          free;
    logic          xfer;
    logic [N-1:0]  req;
    logic [N-1:0]  grant;
    logic [SW-1:0] grant_idx;
    logic [SW-1:0] ptr;
    logic [SW-1:0] ptr_next;
    logic [W-1:0]  grant_data;
    logic          grant_last;

`ifdef STREAM_MUX_PKT_LOCK_EN
    lock_state_t   lock_state;
    lock_state_t   lock_state_next;
    logic [SW-1:0] lock_ch;
    logic [SW-1:0] lock_ch_next;
`endif

    assign free = ~out_valid | out_ready;

    // Eligibility vector fed to the arbiter. Fixed mode and lock present a single
    // candidate so in_ready follows free regardless of in_valid; round-robin presents
    // in_valid so ready only ever accompanies valid. Out-of-range sel matches nothing.
    always_comb begin
        req = '0;
        if (mode == MODE_RR) begin
            req = in_valid;
        end else begin
            for (int k = 0; k < N; k++) begin
                if (sel == SW'(k)) req[k] = 1'b1;
            end
        end
`ifdef STREAM_MUX_PKT_LOCK_EN
        if (lock_state == LOCKED) begin
            req          = '0;
            req[lock_ch] = 1'b1;
        end
`endif
    end

    rr_arbiter #(
        .N  (N),
        .SW (SW)
    ) u_arb (
        .req       (req),
        .ptr       (ptr),
        .advance   (xfer),
        .grant     (grant),
        .grant_idx (grant_idx),
        .ptr_next  (ptr_next)
    );

    // rst_n gates ready combinationally: the output register is empty during reset,
    // so free alone would otherwise advertise readiness.
    assign in_ready = grant & {N{free & rst_n}};
    assign xfer     = |(in_ready & in_valid);

    always_comb begin
        grant_data = '0;
        grant_last = 1'b0;
        for (int k = 0; k < N; k++) begin
            if (grant[k]) begin
                grant_data = in_data[k*W +: W];
                grant_last = in_last[k];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
            out_ch    <= '0;
            ptr       <= '0;
        end else begin
            ptr <= ptr_next;
            if (free) begin
                out_valid <= xfer;
                if (xfer) begin
                    out_data <= grant_data;
                    out_last <= grant_last;
                    out_ch   <= grant_idx;
                end
            end
        end
    end

`ifdef STREAM_MUX_PKT_LOCK_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lock_state <= UNLOCKED;
            lock_ch    <= '0;
        end else begin
            lock_state <= lock_state_next;
            lock_ch    <= lock_ch_next;
        end
    end

    always_comb begin
        lock_state_next = lock_state;
        lock_ch_next    = lock_ch;
        case (lock_state)
            UNLOCKED: begin
                // A single-beat packet (last on the first beat) never locks.
                if (xfer && !grant_last) begin
                    lock_state_next = LOCKED;
                    lock_ch_next    = grant_idx;
                end
            end
            LOCKED: begin
                if (xfer && grant_last) lock_state_next = UNLOCKED;
            end
            default: lock_state_next = UNLOCKED;
        endcase
    end
`endif

endmodule : stream_mux_n

// File: tb/tb_stream_mux_n.sv
module tb_stream_mux_n;

    localparam int N  = 4;
    localparam int W  = 8;
    localparam int SW = 2;

    logic           clk;
    logic           rst_n;
    logic           mode;
    logic [SW-1:0]  sel;
    logic [N-1:0]   in_valid;
    logic [N-1:0]   in_ready;
    logic [N*W-1:0] in_data;
    logic [N-1:0]   in_last;
    logic           out_valid;
    logic           out_ready;
    logic [W-1:0]   out_data;
    logic           out_last;
    logic [SW-1:0]  out_ch;

    int total;
    int bad;

    // Reference state: contents of the output stage, priority pointer, lock.
    logic         m_valid;
    logic [W-1:0] m_data;
    logic         m_last;
    int           m_ch;
    int           m_p;
    logic         m_locked;
    int           m_lock_ch;

    stream_mux_n #(.N(N), .W(W), .SW(SW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .mode      (mode),
        .sel       (sel),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .out_ch    (out_ch)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Which channel the rules say should be granted now; -1 for none.
    function automatic int model_grant();
        if (m_locked) return m_lock_ch;
        if (mode == 1'b0) return (int'(sel) < N) ? int'(sel) : -1;
        for (int i = 0; i < N; i++) begin
            if (in_valid[(m_p + i) % N]) return (m_p + i) % N;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_valid   = 1'b0;
        m_data    = '0;
        m_last    = 1'b0;
        m_ch      = 0;
        m_p       = 0;
        m_locked  = 1'b0;
        m_lock_ch = 0;
    endtask

    // One clock: check outputs and in_ready at negedge, then advance the model at posedge.
    // Inputs are expected to have been driven just after the previous posedge.
    task automatic cycle();
        int           g;
        logic         fr;
        logic [N-1:0] exp_rdy;
        @(negedge clk);
        g       = model_grant();
        fr      = !m_valid || out_ready;
        exp_rdy = '0;
        if (rst_n && fr && g >= 0) exp_rdy[g] = 1'b1;
        chk("in_ready", 32'(in_ready), 32'(exp_rdy));
        chk("out_valid", 32'(out_valid), 32'(m_valid));
        if (m_valid) begin
            chk("out_data", 32'(out_data), 32'(m_data));
            chk("out_last", 32'(out_last), 32'(m_last));
            chk("out_ch", 32'(out_ch), 32'(m_ch));
        end
        @(posedge clk);
        if (rst_n && fr) begin
            if (g >= 0 && in_valid[g]) begin
                m_valid = 1'b1;
                m_data  = in_data[g*W +: W];
                m_last  = in_last[g];
                m_ch    = g;
                m_p     = (g + 1) % N;
`ifdef STREAM_MUX_PKT_LOCK_EN
                if (!m_locked && !in_last[g]) begin
                    m_locked  = 1'b1;
                    m_lock_ch = g;
                end else if (m_locked && in_last[g]) begin
                    m_locked = 1'b0;
                end
`endif
            end else begin
                m_valid = 1'b0;
            end
        end
        #1;
    endtask

    task automatic set_data(input int base);
        for (int k = 0; k < N; k++) in_data[k*W +: W] = W'(base + k);
    endtask

    // Asynchronous reset in the middle of a cycle, checked immediately, held two cycles.
    task automatic do_reset(input string tag);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        chk({tag, "_rst_valid"}, 32'(out_valid), 32'd0);
        chk({tag, "_rst_ready"}, 32'(in_ready), 32'd0);
        chk({tag, "_rst_data"}, 32'(out_data), 32'd0);
        chk({tag, "_rst_last"}, 32'(out_last), 32'd0);
        chk({tag, "_rst_ch"}, 32'(out_ch), 32'd0);
        @(posedge clk);
        #1;
        cycle();
        rst_n = 1'b1;
    endtask

    logic [W-1:0] held;

    initial begin
        total     = 0;
        bad       = 0;
        rst_n     = 1'b0;
        mode      = 1'b1;
        sel       = '0;
        in_valid  = '1;
        in_data   = '0;
        in_last   = '1;
        out_ready = 1'b1;
        model_reset();
        @(posedge clk);
        #1;
        do_reset("init");

        // Round robin, all channels valid: 0,1,2,3,0 one beat per cycle.
        mode = 1'b1; in_valid = 4'b1111; in_last = '1; out_ready = 1'b1; set_data(8'h10);
        for (int i = 0; i < 5; i++) begin
            cycle();
            chk("rr_seq_ch", 32'(out_ch), 32'(i % N));
            chk("rr_seq_valid", 32'(out_valid), 32'd1);
        end

        // Fixed mode, sel=2: others never ready, A5 appears one cycle later.
        mode = 1'b0; sel = 2'd2; set_data(8'h30); in_data[2*W +: W] = 8'hA5;
        for (int i = 0; i < 2; i++) begin
            cycle();
            chk("fix_data", 32'(out_data), 32'hA5);
            chk("fix_ch", 32'(out_ch), 32'd2);
        end

        // Pointer now 3; only channels 0 and 2 valid: expect 0 then 2.
        mode = 1'b1; in_valid = 4'b0101; set_data(8'h50);
        cycle();
        chk("wrap_ch0", 32'(out_ch), 32'd0);
        cycle();
        chk("skip_ch2", 32'(out_ch), 32'd2);

        // Backpressure: three stalled cycles hold the beat and drop all ready.
        in_valid = 4'b1111; set_data(8'h70);
        cycle();
        held = out_data;
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("bp_ready", 32'(in_ready), 32'd0);
            chk("bp_data", 32'(out_data), 32'(held));
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        cycle();
        chk("bp_resume_valid", 32'(out_valid), 32'd1);

        // Randomized traffic against the reference model.
        for (int i = 0; i < 400; i++) begin
            mode      = 1'($urandom % 2);
            sel       = SW'($urandom % N);
            in_valid  = N'($urandom);
            in_last   = N'($urandom);
            in_data   = (N*W)'($urandom);
            out_ready = ($urandom % 4) != 0;
            cycle();
        end

        // Reset while stalled with a held beat; afterwards round robin starts at 0.
        mode = 1'b1; in_valid = 4'b1111; in_last = '1; out_ready = 1'b0;
        cycle();
        do_reset("stall");
        out_ready = 1'b1; set_data(8'h90);
        cycle();
        chk("post_rst_first_ch", 32'(out_ch), 32'd0);
        chk("post_rst_first_valid", 32'(out_valid), 32'd1);

`ifdef STREAM_MUX_PKT_LOCK_EN
        // Channel 1 sends a 3-beat packet while channel 2 waits; a sel/mode change mid-packet is ignored.
        do_reset("lock");
        mode = 1'b0; sel = 2'd0; in_valid = 4'b0001; in_last = '1; out_ready = 1'b1; set_data(8'hB0);
        cycle();
        mode = 1'b1; in_valid = 4'b0110; in_last = 4'b1101;
        cycle();
        chk("lock_b1", 32'(out_ch), 32'd1);
        mode = 1'b0; sel = 2'd2;
        cycle();
        chk("lock_b2", 32'(out_ch), 32'd1);
        in_last = 4'b1111;
        cycle();
        chk("lock_b3", 32'(out_ch), 32'd1);
        cycle();
        chk("lock_after", 32'(out_ch), 32'd2);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_stream_mux_n
